// File: rtl/button_conditioner_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | button_conditioner_if : raw pins in, debounced levels/events out          |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
interface button_conditioner_if #(
  parameter int NUM_BUTTONS = 2
);
  logic [NUM_BUTTONS-1:0]   fpga_push_button;
  logic                     count_clear;
  logic [NUM_BUTTONS-1:0]   button_level;
  logic [NUM_BUTTONS-1:0]   button_press;
  logic [NUM_BUTTONS-1:0]   button_release;
  logic [NUM_BUTTONS-1:0]   button_long;
  logic [8*NUM_BUTTONS-1:0] press_count;

  modport master (
    output fpga_push_button, count_clear,
    input  button_level, button_press, button_release, button_long, press_count
  );

  modport slave (
    input  fpga_push_button, count_clear,
    output button_level, button_press, button_release, button_long, press_count
  );
endinterface
`default_nettype wire

// File: rtl/button_conditioner.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | button_conditioner : sync, debounce, press/release/long events, counters  |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module button_conditioner #(
  parameter int NUM_BUTTONS       = 2,
  parameter int DEBOUNCE_CYCLES   = 1000000,
  parameter int LONG_PRESS_CYCLES = 50000000,
  parameter int BUTTON_ACTIVE_LOW = 1
) (
  input  wire logic            fpga_clk_50,
  input  wire logic            fpga_reset_n,
  button_conditioner_if.slave  bus
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int HW = $clog2(LONG_PRESS_CYCLES + 1);

  localparam logic [DW-1:0] DCNT_LAST    = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DW-1:0] DCNT_ONE     = DW'(1);
  localparam logic [HW-1:0] HCNT_LAST    = HW'(LONG_PRESS_CYCLES - 1);
  localparam logic [HW-1:0] HCNT_MAX     = HW'(LONG_PRESS_CYCLES);
  localparam logic          RAW_RELEASED = (BUTTON_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_PRESS_PEND = 2'd1,
    ST_PRESSED    = 2'd2,
    ST_REL_PEND   = 2'd3
  } state_t;

  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_btn
    logic          sync1_q, sync2_q;
    logic          s;
    state_t        state_q, state_d;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic [HW-1:0] hcnt_q, hcnt_d;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic          long_q, long_d;
    logic [7:0]    count_q, count_d;

    assign s = sync2_q ^ RAW_RELEASED;

    always_comb begin
      state_d   = state_q;
      dcnt_d    = dcnt_q;
      hcnt_d    = hcnt_q;
      level_d   = level_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      long_d    = 1'b0;

      // Hold time keeps running through a release bounce so long-press timing is unaffected.
      if (state_q == ST_PRESSED || state_q == ST_REL_PEND) begin
        if (hcnt_q != HCNT_MAX) begin
          hcnt_d = hcnt_q + 1'b1;
        end
        long_d = (hcnt_q == HCNT_LAST);
      end

      case (state_q)
        ST_IDLE: begin
          if (s) begin
            state_d = ST_PRESS_PEND;
            dcnt_d  = DCNT_ONE;
          end
        end
        ST_PRESS_PEND: begin
          if (!s) begin
            state_d = ST_IDLE;
            dcnt_d  = '0;
          end else if (dcnt_q == DCNT_LAST) begin
            state_d = ST_PRESSED;
            level_d = 1'b1;
            press_d = 1'b1;
            hcnt_d  = '0;
          end else begin
            dcnt_d = dcnt_q + 1'b1;
          end
        end
        ST_PRESSED: begin
          if (!s) begin
            state_d = ST_REL_PEND;
            dcnt_d  = DCNT_ONE;
          end
        end
        ST_REL_PEND: begin
          if (s) begin
            state_d = ST_PRESSED;
          end else if (dcnt_q == DCNT_LAST) begin
            state_d   = ST_IDLE;
            level_d   = 1'b0;
            release_d = 1'b1;
          end else begin
            dcnt_d = dcnt_q + 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase

      // A press coinciding with a clear still counts.
      if (bus.count_clear) begin
        count_d = {7'd0, press_q};
      end else begin
        count_d = count_q + {7'd0, press_q};
      end
    end

    always_ff @(posedge fpga_clk_50 or negedge fpga_reset_n) begin
      if (!fpga_reset_n) begin
        sync1_q   <= RAW_RELEASED;
        sync2_q   <= RAW_RELEASED;
        state_q   <= ST_IDLE;
        dcnt_q    <= '0;
        hcnt_q    <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        long_q    <= 1'b0;
        count_q   <= 8'd0;
      end else begin
        sync1_q   <= bus.fpga_push_button[i];
        sync2_q   <= sync1_q;
        state_q   <= state_d;
        dcnt_q    <= dcnt_d;
        hcnt_q    <= hcnt_d;
        level_q   <= level_d;
        press_q   <= press_d;
        release_q <= release_d;
        long_q    <= long_d;
        count_q   <= count_d;
      end
    end

    assign bus.button_level[i]       = level_q;
    assign bus.button_press[i]       = press_q;
    assign bus.button_release[i]     = release_q;
    assign bus.button_long[i]        = long_q;
    assign bus.press_count[8*i +: 8] = count_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_button_conditioner.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_button_conditioner : random and directed stimulus against a model      |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_button_conditioner;
  localparam int NB = 2;
  localparam int D  = 4;
  localparam int L  = 20;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #10 clk = ~clk;

  button_conditioner_if #(.NUM_BUTTONS(NB)) bus ();

  button_conditioner #(
    .NUM_BUTTONS      (NB),
    .DEBOUNCE_CYCLES  (D),
    .LONG_PRESS_CYCLES(L),
    .BUTTON_ACTIVE_LOW(1)
  ) dut (
    .fpga_clk_50 (clk),
    .fpga_reset_n(rst_n),
    .bus         (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: per-button run length of disagreement between the
  // synchronized pin and the accepted level, plus time held since acceptance.
  logic [NB-1:0]   pr;
  int              m_run  [NB];
  int              m_hold [NB];
  int              m_cnt  [NB];
  logic            m_sy1  [NB];
  logic            m_sy2  [NB];
  logic [NB-1:0]   e_level, e_press, e_rel, e_long;
  logic [8*NB-1:0] e_count;

  task automatic model_reset();
    for (int b = 0; b < NB; b++) begin
      m_run[b] = 0; m_hold[b] = 0; m_cnt[b] = 0;
      m_sy1[b] = 1'b0; m_sy2[b] = 1'b0;
    end
    e_level = '0; e_press = '0; e_rel = '0; e_long = '0; e_count = '0;
  endtask

  task automatic model_step(input logic clr);
    logic [NB-1:0] np, nr, nl;
    if (!rst_n) begin
      model_reset();
      return;
    end
    np = '0; nr = '0; nl = '0;
    for (int b = 0; b < NB; b++) begin
      if (clr) m_cnt[b] = e_press[b] ? 1 : 0;
      else     m_cnt[b] = (m_cnt[b] + (e_press[b] ? 1 : 0)) % 256;
      if (e_level[b] && m_hold[b] < L) begin
        m_hold[b]++;
        if (m_hold[b] == L) nl[b] = 1'b1;
      end
      if (m_sy2[b] != e_level[b]) begin
        m_run[b]++;
        if (m_run[b] == D) begin
          e_level[b] = m_sy2[b];
          m_run[b]   = 0;
          if (m_sy2[b]) begin np[b] = 1'b1; m_hold[b] = 0; end
          else nr[b] = 1'b1;
        end
      end else begin
        m_run[b] = 0;
      end
      m_sy2[b] = m_sy1[b];
      m_sy1[b] = pr[b];
      e_count[8*b +: 8] = 8'(m_cnt[b]);
    end
    e_press = np; e_rel = nr; e_long = nl;
  endtask

  function automatic logic [12*NB-1:0] obs();
    return {bus.button_level, bus.button_press, bus.button_release, bus.button_long, bus.press_count};
  endfunction

  function automatic logic [12*NB-1:0] expv();
    return {e_level, e_press, e_rel, e_long, e_count};
  endfunction

  // One clock: drive inputs, step model at the edge, return at the falling edge.
  task automatic cycle(input logic [NB-1:0] p, input logic clr);
    pr = p;
    bus.fpga_push_button = ~p;
    bus.count_clear = clr;
    @(posedge clk);
    model_step(clr);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    pr = '0; bus.fpga_push_button = '1; bus.count_clear = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    n_checks++;
    if (obs() !== '0) $display("FAIL reset_outputs actual=%h expected=0", obs()); else n_pass++;
    rst_n = 1'b1;
  endtask

  task automatic test_clean_press();
    int at_p = -1, at_r = -1;
    for (int c = 0; c < 20; c++) begin
      cycle((c < 10) ? 2'b01 : 2'b00, 1'b0);
      n_checks++;
      if (obs() !== expv()) $display("FAIL clean_press c=%0d actual=%h expected=%h", c, obs(), expv()); else n_pass++;
      if (bus.button_press[0] && at_p < 0) at_p = c;
      if (bus.button_release[0] && at_r < 0) at_r = c;
    end
    n_checks++;
    if (at_p !== 5) $display("FAIL clean_press_latency actual=%0d expected=5", at_p); else n_pass++;
    n_checks++;
    if (at_r !== 15) $display("FAIL clean_release_latency actual=%0d expected=15", at_r); else n_pass++;
    n_checks++;
    if (bus.press_count[7:0] !== 8'd1) $display("FAIL clean_press_count actual=%0d expected=1", bus.press_count[7:0]); else n_pass++;
  endtask

  task automatic test_bounce();
    int at_p = -1, n_p = 0;
    for (int c = 0; c < 26; c++) begin
      cycle((c == 0 || c == 1 || (c >= 3 && c < 14)) ? 2'b10 : 2'b00, 1'b0);
      n_checks++;
      if (obs() !== expv()) $display("FAIL bounce c=%0d actual=%h expected=%h", c, obs(), expv()); else n_pass++;
      if (bus.button_press[1]) begin n_p++; if (at_p < 0) at_p = c; end
    end
    n_checks++;
    if (at_p !== 8 || n_p !== 1) $display("FAIL bounce_accept at=%0d n=%0d expected at=8 n=1", at_p, n_p); else n_pass++;
  endtask

  task automatic test_long_press();
    int at_l = -1, n_l = 0, at_r = -1;
    for (int c = 0; c < 45; c++) begin
      cycle((c < 35) ? 2'b01 : 2'b00, 1'b0);
      n_checks++;
      if (obs() !== expv()) $display("FAIL long_hold c=%0d actual=%h expected=%h", c, obs(), expv()); else n_pass++;
      if (bus.button_long[0]) begin n_l++; if (at_l < 0) at_l = c; end
    end
    n_checks++;
    if (at_l !== 25 || n_l !== 1) $display("FAIL long_pulse at=%0d n=%0d expected at=25 n=1", at_l, n_l); else n_pass++;
    n_l = 0;
    for (int c = 0; c < 26; c++) begin
      cycle((c < 15) ? 2'b01 : 2'b00, 1'b0);
      n_checks++;
      if (obs() !== expv()) $display("FAIL short_hold c=%0d actual=%h expected=%h", c, obs(), expv()); else n_pass++;
      if (bus.button_long[0]) n_l++;
      if (bus.button_release[0] && at_r < 0) at_r = c;
    end
    n_checks++;
    if (n_l !== 0 || at_r !== 20) $display("FAIL short_no_long longs=%0d rel_at=%0d expected 0 and 20", n_l, at_r); else n_pass++;
  endtask

  task automatic test_release_bounce();
    int at_l = -1, n_r = 0;
    for (int c = 0; c < 48; c++) begin
      cycle((c < 35 && c != 10 && c != 11) ? 2'b01 : 2'b00, 1'b0);
      n_checks++;
      if (obs() !== expv()) $display("FAIL rel_bounce c=%0d actual=%h expected=%h", c, obs(), expv()); else n_pass++;
      if (bus.button_long[0] && at_l < 0) at_l = c;
      if (bus.button_release[0] && c < 35) n_r++;
    end
    n_checks++;
    if (at_l !== 25 || n_r !== 0) $display("FAIL rel_bounce_long long_at=%0d early_rel=%0d expected 25 and 0", at_l, n_r); else n_pass++;
  endtask

  task automatic test_count_wrap_clear();
    bit seen = 0;
    cycle(2'b00, 1'b1);
    for (int k = 0; k < 256; k++) begin
      for (int c = 0; c < 14; c++) begin
        cycle((c < 7) ? 2'b10 : 2'b00, 1'b0);
        n_checks++;
        if (obs() !== expv()) $display("FAIL wrap k=%0d c=%0d actual=%h expected=%h", k, c, obs(), expv()); else n_pass++;
      end
    end
    cycle(2'b00, 1'b0);
    n_checks++;
    if (bus.press_count[15:8] !== 8'd0) $display("FAIL wrap_zero actual=%0d expected=0", bus.press_count[15:8]); else n_pass++;
    for (int c = 0; c < 20 && !seen; c++) begin
      cycle(2'b10, 1'b0);
      seen = bus.button_press[1];
    end
    n_checks++;
    if (!seen) $display("FAIL clear_press_timeout actual=no_press expected=press"); else n_pass++;
    cycle(2'b10, 1'b1);
    n_checks++;
    if (bus.press_count[15:8] !== 8'd1 || obs() !== expv())
      $display("FAIL clear_with_press actual=%h expected count1=1 model=%h", obs(), expv());
    else n_pass++;
    repeat (10) cycle(2'b00, 1'b0);
    cycle(2'b00, 1'b1);
    n_checks++;
    if (bus.press_count !== '0 || obs() !== expv()) $display("FAIL clear_alone actual=%h expected=0", bus.press_count); else n_pass++;
  endtask

  task automatic test_random();
    logic [NB-1:0] p = '0;
    int left [NB];
    logic clr;
    for (int b = 0; b < NB; b++) left[b] = 0;
    for (int c = 0; c < 4000; c++) begin
      for (int b = 0; b < NB; b++) begin
        if (left[b] == 0) begin
          p[b] = ~p[b];
          left[b] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : $urandom_range(5, 40);
        end
        left[b]--;
      end
      clr = ($urandom_range(0, 63) == 0);
      cycle(p, clr);
      n_checks++;
      if (obs() !== expv()) $display("FAIL random c=%0d actual=%h expected=%h", c, obs(), expv()); else n_pass++;
    end
    repeat (50) cycle(2'b00, 1'b0);
  endtask

  task automatic test_reset_mid();
    int at_p = -1;
    for (int c = 0; c < 13; c++) begin
      cycle((c < 10) ? 2'b10 : 2'b11, 1'b0);
      n_checks++;
      if (obs() !== expv()) $display("FAIL reset_mid_pre c=%0d actual=%h expected=%h", c, obs(), expv()); else n_pass++;
    end
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if (obs() !== '0) $display("FAIL reset_mid_async actual=%h expected=0", obs()); else n_pass++;
    repeat (2) cycle(2'b11, 1'b0);
    rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      cycle(2'b11, 1'b0);
      n_checks++;
      if (obs() !== expv()) $display("FAIL reset_mid_post c=%0d actual=%h expected=%h", c, obs(), expv()); else n_pass++;
      if (bus.button_press[0] && at_p < 0) at_p = c;
    end
    n_checks++;
    if (at_p !== 5) $display("FAIL reset_mid_repress actual=%0d expected=5", at_p); else n_pass++;
    repeat (40) cycle(2'b00, 1'b0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_long_press();
    test_release_bounce();
    test_count_wrap_clear();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
